// File: rtl/mem_bus_pkg.sv
// Shared types for the two-requester memory bus arbiter.
//  arb_state_t : arbiter FSM states
//  mem_req_t   : one captured bus request (address, write data, write enable, byte lanes)
//  GRANT_A/B   : encoding of the grant / last_grant bit
package mem_bus_pkg;
  localparam int ADDR_HI_DEF = 19;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ADDR_HI_DEF:1] addr;
    logic [15:0]          data;
    logic                 wr_en;
    logic [1:0]           bytesel;
  } mem_req_t;

  localparam logic GRANT_A = 1'b0;
  localparam logic GRANT_B = 1'b1;
endpackage

// File: rtl/arb_pick2.sv
// Combinational two-way picker.
//  i_req_a/i_req_b : pending requests
//  i_last_grant    : owner of the previous transaction
//  o_grant         : GRANT_A / GRANT_B (GRANT_A when nobody requests; caller ignores it then)
// A sole requester always wins. On a tie B wins when DATA_PRIORITY is set, otherwise
// whoever did not own the previous transaction wins.
module arb_pick2
  import mem_bus_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1
) (
  input  logic i_req_a,
  input  logic i_req_b,
  input  logic i_last_grant,
  output logic o_grant
);
  always_comb begin
    o_grant = GRANT_A;
    if (i_req_a && i_req_b)
      o_grant = (DATA_PRIORITY || (i_last_grant == GRANT_A)) ? GRANT_B : GRANT_A;
    else if (i_req_b)
      o_grant = GRANT_B;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single CPU memory port.
//  A = instruction prefetch, B = load/store unit.
//  a_m_* / b_m_* : requester side (addr, data_out, access, wr_en, bytesel in; ack, data_in out)
//  q_m_*         : shared bus side (addr, data_out, access, wr_en, bytesel out; ack, data_in in)
// One whole transaction (access..ack) is granted at a time. The winner's request is
// registered onto q_* on the grant edge and held until q_m_ack; the bus is cleared and
// the FSM returns to IDLE on the edge after the ack, so consecutive transactions are
// separated by at least one idle bus cycle. Read data is broadcast; only the acked owner
// sees an ack.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter bit DATA_PRIORITY = 1'b1,
  parameter int ADDR_HI       = ADDR_HI_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ADDR_HI:1] a_m_addr,
  input  logic [15:0]      a_m_data_out,
  input  logic             a_m_access,
  input  logic             a_m_wr_en,
  input  logic [1:0]       a_m_bytesel,
  output logic             a_m_ack,
  output logic [15:0]      a_m_data_in,
  input  logic [ADDR_HI:1] b_m_addr,
  input  logic [15:0]      b_m_data_out,
  input  logic             b_m_access,
  input  logic             b_m_wr_en,
  input  logic [1:0]       b_m_bytesel,
  output logic             b_m_ack,
  output logic [15:0]      b_m_data_in,
  output logic [ADDR_HI:1] q_m_addr,
  output logic [15:0]      q_m_data_out,
  output logic             q_m_access,
  output logic             q_m_wr_en,
  output logic [1:0]       q_m_bytesel,
  input  logic             q_m_ack,
  input  logic [15:0]      q_m_data_in
);
  arb_state_t r_state, w_next_state;
  mem_req_t   r_q, w_req_a, w_req_b;
  logic       r_q_access, r_last_grant;
  logic       w_grant, w_load, w_done;

  assign w_req_a = {a_m_addr, a_m_data_out, a_m_wr_en, a_m_bytesel};
  assign w_req_b = {b_m_addr, b_m_data_out, b_m_wr_en, b_m_bytesel};

  arb_pick2 #(.DATA_PRIORITY(DATA_PRIORITY)) u_pick (
    .i_req_a      (a_m_access),
    .i_req_b      (b_m_access),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // Acks only count while a grant is held; an ack seen in IDLE is dropped.
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (a_m_access || b_m_access) begin
          w_load       = 1'b1;
          w_next_state = (w_grant == GRANT_B) ? SERVE_B : SERVE_A;
        end
      end
      SERVE_A, SERVE_B: begin
        if (q_m_ack) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_q          <= '0;
      r_q_access   <= 1'b0;
      r_last_grant <= GRANT_A;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_q        <= (w_grant == GRANT_B) ? w_req_b : w_req_a;
        r_q_access <= 1'b1;
      end else if (w_done) begin
        r_q          <= '0;
        r_q_access   <= 1'b0;
        r_last_grant <= (r_state == SERVE_B) ? GRANT_B : GRANT_A;
      end
    end
  end

  assign q_m_addr     = r_q.addr;
  assign q_m_data_out = r_q.data;
  assign q_m_wr_en    = r_q.wr_en;
  assign q_m_bytesel  = r_q.bytesel;
  assign q_m_access   = r_q_access;

  assign a_m_ack     = q_m_ack & (r_state == SERVE_A);
  assign b_m_ack     = q_m_ack & (r_state == SERVE_B);
  assign a_m_data_in = q_m_data_in;
  assign b_m_data_in = q_m_data_in;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter. Two instances share all inputs:
// u_dut1 (DATA_PRIORITY=1) and u_dut0 (DATA_PRIORITY=0, used for round-robin).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mem_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [19:1] a_addr, b_addr;
  logic [15:0] a_dout, b_dout;
  logic        a_acc, b_acc, a_wr, b_wr;
  logic [1:0]  a_bs, b_bs;
  logic        q_ack;
  logic [15:0] q_din;

  logic        a_ack1, b_ack1, q_acc1, q_wr1;
  logic [15:0] a_din1, b_din1, q_dout1;
  logic [19:1] q_addr1;
  logic [1:0]  q_bs1;
  logic        a_ack0, b_ack0, q_acc0, q_wr0;
  logic [15:0] a_din0, b_din0, q_dout0;
  logic [19:1] q_addr0;
  logic [1:0]  q_bs0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_PRIORITY(1'b1), .ADDR_HI(19)) u_dut1 (
    .clk(clk), .reset(reset),
    .a_m_addr(a_addr), .a_m_data_out(a_dout), .a_m_access(a_acc), .a_m_wr_en(a_wr),
    .a_m_bytesel(a_bs), .a_m_ack(a_ack1), .a_m_data_in(a_din1),
    .b_m_addr(b_addr), .b_m_data_out(b_dout), .b_m_access(b_acc), .b_m_wr_en(b_wr),
    .b_m_bytesel(b_bs), .b_m_ack(b_ack1), .b_m_data_in(b_din1),
    .q_m_addr(q_addr1), .q_m_data_out(q_dout1), .q_m_access(q_acc1), .q_m_wr_en(q_wr1),
    .q_m_bytesel(q_bs1), .q_m_ack(q_ack), .q_m_data_in(q_din)
  );

  mem_bus_arbiter #(.DATA_PRIORITY(1'b0), .ADDR_HI(19)) u_dut0 (
    .clk(clk), .reset(reset),
    .a_m_addr(a_addr), .a_m_data_out(a_dout), .a_m_access(a_acc), .a_m_wr_en(a_wr),
    .a_m_bytesel(a_bs), .a_m_ack(a_ack0), .a_m_data_in(a_din0),
    .b_m_addr(b_addr), .b_m_data_out(b_dout), .b_m_access(b_acc), .b_m_wr_en(b_wr),
    .b_m_bytesel(b_bs), .b_m_ack(b_ack0), .b_m_data_in(b_din0),
    .q_m_addr(q_addr0), .q_m_data_out(q_dout0), .q_m_access(q_acc0), .q_m_wr_en(q_wr0),
    .q_m_bytesel(q_bs0), .q_m_ack(q_ack), .q_m_data_in(q_din)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_addr = '0; b_addr = '0; a_dout = '0; b_dout = '0;
    a_acc = 0; b_acc = 0; a_wr = 0; b_wr = 0; a_bs = '0; b_bs = '0;
    q_ack = 0; q_din = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    tick(); tick();
    n_tests++; if ({q_acc1, q_wr1, q_addr1, q_dout1, q_bs1} !== '0) begin n_fail++;
      $display("FAIL reset_q got acc=%0b wr=%0b addr=%h dout=%h bs=%b exp all 0", q_acc1, q_wr1, q_addr1, q_dout1, q_bs1); end
    n_tests++; if ({a_ack1, b_ack1} !== 2'b00) begin n_fail++;
      $display("FAIL reset_acks got a=%0b b=%0b exp 0 0", a_ack1, b_ack1); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_b_read();
    test_reset();
    b_addr = 19'h12345; b_bs = 2'b11; b_acc = 1;
    n_tests++; if (q_acc1 !== 1'b0) begin n_fail++; $display("FAIL b_read_latency got acc=%0b exp 0", q_acc1); end
    tick();
    n_tests++; if (q_acc1 !== 1'b1 || q_addr1 !== 19'h12345 || q_bs1 !== 2'b11 || q_wr1 !== 1'b0) begin n_fail++;
      $display("FAIL b_read_bus got acc=%0b addr=%h bs=%b wr=%0b exp 1 12345 11 0", q_acc1, q_addr1, q_bs1, q_wr1); end
    tick(); tick();
    q_ack = 1; q_din = 16'hBEEF; b_acc = 0;
    #1;
    n_tests++; if (b_ack1 !== 1'b1 || b_din1 !== 16'hBEEF || a_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL b_read_ack got b_ack=%0b data=%h a_ack=%0b exp 1 beef 0", b_ack1, b_din1, a_ack1); end
    tick(); q_ack = 0;
    n_tests++; if (q_acc1 !== 1'b0 || q_addr1 !== '0 || q_bs1 !== 2'b00 || b_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL b_read_release got acc=%0b addr=%h bs=%b b_ack=%0b exp 0 0 00 0", q_acc1, q_addr1, q_bs1, b_ack1); end
  endtask

  task automatic test_priority();
    test_reset();
    a_addr = 19'h00100; a_acc = 1; b_addr = 19'h00200; b_acc = 1;
    tick();
    n_tests++; if (q_acc1 !== 1'b1 || q_addr1 !== 19'h00200) begin n_fail++;
      $display("FAIL prio_first got acc=%0b addr=%h exp 1 00200", q_acc1, q_addr1); end
    q_ack = 1; #1;
    n_tests++; if (b_ack1 !== 1'b1 || a_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL prio_first_ack got b=%0b a=%0b exp 1 0", b_ack1, a_ack1); end
    b_acc = 0;
    tick(); q_ack = 0;
    n_tests++; if (q_acc1 !== 1'b0) begin n_fail++; $display("FAIL prio_gap got acc=%0b exp 0", q_acc1); end
    tick();
    n_tests++; if (q_acc1 !== 1'b1 || q_addr1 !== 19'h00100) begin n_fail++;
      $display("FAIL prio_second got acc=%0b addr=%h exp 1 00100", q_acc1, q_addr1); end
    q_ack = 1; #1;
    n_tests++; if (a_ack1 !== 1'b1 || b_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL prio_second_ack got a=%0b b=%0b exp 1 0", a_ack1, b_ack1); end
    a_acc = 0;
    tick(); q_ack = 0;
  endtask

  task automatic test_round_robin();
    logic [19:1] exp_addr [4] = '{19'h00222, 19'h00111, 19'h00222, 19'h00111};
    logic        exp_b    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    test_reset();
    a_addr = 19'h00111; a_acc = 1; b_addr = 19'h00222; b_acc = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (q_acc0 !== 1'b1 || q_addr0 !== exp_addr[i]) begin n_fail++;
        $display("FAIL rr_grant%0d got acc=%0b addr=%h exp 1 %h", i, q_acc0, q_addr0, exp_addr[i]); end
      q_ack = 1; #1;
      n_tests++; if (b_ack0 !== exp_b[i] || a_ack0 !== !exp_b[i]) begin n_fail++;
        $display("FAIL rr_ack%0d got b=%0b a=%0b exp b=%0b", i, b_ack0, a_ack0, exp_b[i]); end
      tick(); q_ack = 0;
      n_tests++; if (q_acc0 !== 1'b0) begin n_fail++; $display("FAIL rr_gap%0d got acc=%0b exp 0", i, q_acc0); end
    end
    a_acc = 0; b_acc = 0;
  endtask

  task automatic test_write_hold();
    test_reset();
    b_addr = 19'h00040; b_dout = 16'h00A5; b_wr = 1; b_bs = 2'b10; b_acc = 1;
    tick();
    b_dout = 16'h0000; b_addr = 19'h00999; b_bs = 2'b01;
    tick();
    n_tests++; if (q_dout1 !== 16'h00A5 || q_wr1 !== 1'b1 || q_addr1 !== 19'h00040 || q_bs1 !== 2'b10) begin n_fail++;
      $display("FAIL wr_hold got dout=%h wr=%0b addr=%h bs=%b exp 00a5 1 00040 10", q_dout1, q_wr1, q_addr1, q_bs1); end
    q_ack = 1; b_acc = 0;
    tick(); q_ack = 0;
    n_tests++; if (q_dout1 !== 16'h0000 || q_wr1 !== 1'b0) begin n_fail++;
      $display("FAIL wr_release got dout=%h wr=%0b exp 0000 0", q_dout1, q_wr1); end
    b_wr = 0;
  endtask

  task automatic test_reset_mid();
    test_reset();
    a_addr = 19'h00055; a_acc = 1;
    tick(); tick();
    reset = 1; a_acc = 0; #1;
    n_tests++; if (q_acc1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_async got acc=%0b exp 0", q_acc1); end
    tick(); reset = 0;
    tick();
    q_ack = 1; #1;
    n_tests++; if (a_ack1 !== 1'b0 || b_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL rst_mid_stale got a=%0b b=%0b exp 0 0", a_ack1, b_ack1); end
    tick(); q_ack = 0;
    n_tests++; if (q_acc1 !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got acc=%0b exp 0", q_acc1); end
  endtask

  task automatic test_drop_access();
    int pulses = 0;
    test_reset();
    a_addr = 19'h00066; a_acc = 1;
    tick(); a_acc = 0;
    tick(); tick();
    n_tests++; if (q_acc1 !== 1'b1 || q_addr1 !== 19'h00066) begin n_fail++;
      $display("FAIL drop_hold got acc=%0b addr=%h exp 1 00066", q_acc1, q_addr1); end
    q_ack = 1; #1;
    pulses += int'(a_ack1);
    tick(); q_ack = 0;
    for (int i = 0; i < 3; i++) begin pulses += int'(a_ack1); tick(); end
    n_tests++; if (pulses != 1) begin n_fail++; $display("FAIL drop_ack_pulses got %0d exp 1", pulses); end
    n_tests++; if (q_acc1 !== 1'b0) begin n_fail++; $display("FAIL drop_idle got acc=%0b exp 0", q_acc1); end
  endtask

  task automatic test_idle_ack();
    test_reset();
    q_ack = 1; #1;
    n_tests++; if (a_ack1 !== 1'b0 || b_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL idle_ack_alone got a=%0b b=%0b exp 0 0", a_ack1, b_ack1); end
    a_addr = 19'h00301; a_acc = 1; b_addr = 19'h00302; b_acc = 1; #1;
    n_tests++; if (a_ack1 !== 1'b0 || b_ack1 !== 1'b0) begin n_fail++;
      $display("FAIL idle_ack_req got a=%0b b=%0b exp 0 0", a_ack1, b_ack1); end
    tick(); q_ack = 0; a_acc = 0; b_acc = 0;
    n_tests++; if (q_acc1 !== 1'b1 || q_addr1 !== 19'h00302) begin n_fail++;
      $display("FAIL idle_ack_arb got acc=%0b addr=%h exp 1 00302", q_acc1, q_addr1); end
    q_ack = 1;
    tick(); q_ack = 0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_b_read();
    test_priority();
    test_round_robin();
    test_write_hold();
    test_reset_mid();
    test_drop_access();
    test_idle_ack();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
